// File: rtl/packet_adder_arb.sv
// Round-robin arbiter that grants one requester at a time ownership of a shared packet adder for a whole packet.
// Latency: one IDLE arbitration cycle before the first beat; beats then pass through combinationally.
// Backpressure: out_ready is passed straight to the owner's req_ready; every other requester sees req_ready=0.
//
// Ports:
//   clk, rst_n            single rising-edge clock, asynchronous active-low reset
//   req_valid/data/last   per-requester beat stream (requester i data at [i*DATA_W +: DATA_W])
//   req_ready             per-requester beat accept (only the current owner can be ready)
//   out_valid/data/last   muxed beat stream toward the packet adder
//   out_ready             packet adder accept
//   grant_id              index of the current owner, meaningful while busy=1
//   busy                  high while a packet transfer owns the adder
//   wdog_err              one-cycle pulse when a packet is cut off after MAX_BEATS beats without last
module packet_adder_arb #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      wdog_err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [ID_W-1:0]   grant_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic              wdog_nxt;

  logic [ID_W-1:0]   pick;
  logic              pick_vld;
  logic              hs;
  logic              wdog_hit;
  logic [ID_W-1:0]   grant_inc;

  // Round-robin scan starting at ptr. Walking the offsets from the far end
  // down to zero lets the smallest offset (closest to ptr) overwrite the
  // others, so no priority encoder chain with an early exit is needed.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (req_valid[idx]) begin
        pick     = ID_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Beat path: purely combinational mux from the owner. In IDLE nothing is
  // accepted and nothing is presented, even if requesters are valid.
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = req_data[grant_id*DATA_W +: DATA_W];
    if (state == XFER) begin
      out_valid           = req_valid[grant_id];
      out_last            = req_last[grant_id];
      req_ready[grant_id] = out_ready;
    end
  end

  assign hs   = out_valid & out_ready;
  assign busy = (state == XFER);

  // The watchdog fires on the MAX_BEATS-th accepted beat only when that beat
  // is not itself the last one; a last beat always wins as normal completion.
  assign wdog_hit = hs & ~out_last & (beat_cnt == CNT_W'(MAX_BEATS - 1));

  // Next owner after the current one, wrapping without relying on N_REQ
  // being a power of two.
  assign grant_inc = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    grant_nxt    = grant_id;
    beat_cnt_nxt = beat_cnt;
    wdog_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt    = XFER;
          grant_nxt    = pick;
          beat_cnt_nxt = '0;
        end
      end
      XFER: begin
        // Bubbles (owner valid low) leave the counter alone; only accepted
        // beats count toward the watchdog limit.
        if (hs) begin
          if (out_last || wdog_hit) begin
            state_nxt    = IDLE;
            ptr_nxt      = grant_inc;
            beat_cnt_nxt = '0;
            wdog_nxt     = wdog_hit;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant_id <= grant_nxt;
      beat_cnt <= beat_cnt_nxt;
      wdog_err <= wdog_nxt;
    end
  end

endmodule

// File: tb/tb_packet_adder_arb.sv
`timescale 1ns/1ps
module tb_packet_adder_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            out_valid, out_last, out_ready, busy, wdog_err;
  logic [DW-1:0]   out_data;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  packet_adder_arb #(.N_REQ(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy), .wdog_err(wdog_err)
  );

  typedef struct { logic [7:0] d; logic l; } beat_t;
  typedef struct { logic [7:0] d; logic l; logic [1:0] g; } exp_t;
  // Table rows are listed in the order the packets must leave the arbiter.
  typedef struct { int grp; int src; int beats; logic [7:0] base; logic bp; logic gap; } pkt_t;

  beat_t        src_q[N][$];
  exp_t         sb[$];
  pkt_t         tbl[$];
  int           n_cmp = 0, n_fail = 0, wdog_cnt = 0, cyc = 0;
  logic         bp_on = 1'b0;
  logic [N-1:0] gap_mask = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic push_exp(input int s, input logic [7:0] base, input int k, input int nb);
    exp_t e;
    e.d = base + 8'(k);
    e.l = (k == nb - 1);
    e.g = 2'(s);
    sb.push_back(e);
  endtask

  task automatic load_pkt(input int s, input int nb, input logic [7:0] base, input bit with_exp);
    for (int k = 0; k < nb; k++) begin
      beat_t b;
      b.d = base + 8'(k);
      b.l = (k == nb - 1);
      src_q[s].push_back(b);
      if (with_exp) push_exp(s, base, k, nb);
    end
  endtask

  task automatic drive();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !(gap_mask[i] && cyc[0])) begin
        req_valid[i]           = 1'b1;
        req_data[i*DW +: DW]   = src_q[i][0].d;
        req_last[i]            = src_q[i][0].l;
      end
    end
  endtask

  // One clock: monitor at the falling edge, retire accepted beats and
  // re-drive just after the rising edge.
  task automatic tick();
    logic [N-1:0] acc;
    exp_t         e;
    @(negedge clk);
    cyc++;
    acc = req_valid & req_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat: got data %0h from grant %0d, required no beat", out_data, grant_id);
      end else begin
        e = sb.pop_front();
        chk("beat_data", {24'h0, out_data}, {24'h0, e.d});
        chk("beat_last", {31'h0, out_last}, {31'h0, e.l});
        chk("beat_grant", {30'h0, grant_id}, {30'h0, e.g});
      end
    end
    if (busy) begin
      chk("owner_ready", {28'h0, req_ready}, {28'h0, ({3'b000, out_ready} << grant_id)});
    end else begin
      chk("idle_req_ready", {28'h0, req_ready}, 32'h0);
      chk("idle_out_valid", {31'h0, out_valid}, 32'h0);
    end
    if (wdog_err) begin
      wdog_cnt++;
      chk("wdog_busy_low", {31'h0, busy}, 32'h0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(src_q[i].pop_front());
    if (bp_on) out_ready = ~out_ready;
    drive();
  endtask

  task automatic run(input int limit);
    for (int t = 0; t < limit && sb.size() > 0; t++) tick();
    chk("drain", sb.size(), 0);
    tick();
    tick();
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) src_q[i].delete();
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    out_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    #2;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_req_ready", {28'h0, req_ready}, 32'h0);
    chk("rst_wdog", {31'h0, wdog_err}, 32'h0);
    chk("rst_grant", {30'h0, grant_id}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request: busy only after the arbitration cycle, grant 0.
    load_pkt(0, 3, 8'h10, 1'b1);
    drive();
    @(negedge clk);
    chk("arb_cycle_busy", {31'h0, busy}, 32'h0);
    chk("arb_cycle_out_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("first_busy", {31'h0, busy}, 32'h1);
    chk("first_grant", {30'h0, grant_id}, 32'h0);
    run(50);
    // Pointer has moved to 1, so requester 1 beats requester 0.
    load_pkt(1, 2, 8'h20, 1'b1);
    load_pkt(0, 2, 8'h30, 1'b1);
    drive();
    run(50);

    rst_n = 1'b0;
    flush();
    drive();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // grp 0: round robin 0,1,2,3,0; 1: backpressure; 2: owner bubbles;
    // 3: last on the 16th beat; 4-6: pointer-dependent orders.
    tbl.push_back('{0, 0, 2, 8'h40, 1'b0, 1'b0});
    tbl.push_back('{0, 1, 2, 8'h50, 1'b0, 1'b0});
    tbl.push_back('{0, 2, 2, 8'h60, 1'b0, 1'b0});
    tbl.push_back('{0, 3, 2, 8'h70, 1'b0, 1'b0});
    tbl.push_back('{0, 0, 2, 8'h80, 1'b0, 1'b0});
    tbl.push_back('{1, 1, 3, 8'h90, 1'b1, 1'b0});
    tbl.push_back('{2, 3, 3, 8'hA0, 1'b0, 1'b1});
    tbl.push_back('{3, 2, 16, 8'hB0, 1'b0, 1'b0});
    tbl.push_back('{4, 3, 2, 8'hC0, 1'b0, 1'b0});
    tbl.push_back('{4, 1, 2, 8'hC8, 1'b0, 1'b0});
    tbl.push_back('{5, 0, 1, 8'hD0, 1'b0, 1'b0});
    tbl.push_back('{5, 0, 1, 8'hD8, 1'b0, 1'b0});
    tbl.push_back('{6, 2, 2, 8'hE0, 1'b1, 1'b0});
    tbl.push_back('{6, 0, 2, 8'hE8, 1'b1, 1'b0});

    for (int g = 0; g <= 6; g++) begin
      foreach (tbl[r]) begin
        if (tbl[r].grp == g) begin
          load_pkt(tbl[r].src, tbl[r].beats, tbl[r].base, 1'b1);
          if (tbl[r].bp) bp_on = 1'b1;
          if (tbl[r].gap) gap_mask[tbl[r].src] = 1'b1;
        end
      end
      drive();
      run(300);
      bp_on     = 1'b0;
      gap_mask  = '0;
      out_ready = 1'b1;
      drive();
    end
    chk("no_wdog_yet", wdog_cnt, 0);

    // Watchdog: requester 1 sends 20 beats, cut after 16; requester 2 is
    // next, then requester 1's remaining 4 beats form a fresh packet.
    load_pkt(1, 20, 8'h00, 1'b0);
    for (int k = 0; k < 16; k++) push_exp(1, 8'h00, k, 20);
    load_pkt(2, 2, 8'hF0, 1'b1);
    for (int k = 16; k < 20; k++) push_exp(1, 8'h00, k, 20);
    drive();
    run(200);
    chk("wdog_pulses", wdog_cnt, 1);

    // No preemption: requester 2 appears mid-packet of requester 1.
    load_pkt(1, 4, 8'h60, 1'b1);
    drive();
    tick(); tick(); tick();
    load_pkt(2, 2, 8'h70, 1'b1);
    drive();
    run(100);

    // Reset after two beats of requester 3's packet.
    load_pkt(3, 6, 8'h90, 1'b0);
    push_exp(3, 8'h90, 0, 6);
    push_exp(3, 8'h90, 1, 6);
    drive();
    for (int t = 0; t < 50 && sb.size() > 0; t++) tick();
    chk("drain_pre_rst", sb.size(), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_req_ready", {28'h0, req_ready}, 32'h0);
    chk("midrst_grant", {30'h0, grant_id}, 32'h0);
    tick(); tick();
    flush();
    drive();
    rst_n = 1'b1;
    load_pkt(1, 2, 8'hA8, 1'b1);
    load_pkt(3, 2, 8'hB8, 1'b1);
    drive();
    run(100);
    chk("wdog_pulses_final", wdog_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_adder_arb.md
PACKET_ADDER_ARB -- requirements
Module: packet_adder_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the packet adder (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, width of one packet beat.
REQ-003 SHALL have parameter MAX_BEATS, default 16, watchdog limit on beats per packet.
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester beat valid.
REQ-007 SHALL have port req_data  input  N_REQ*DATA_W  per-requester beat data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_last  input  N_REQ  per-requester last-beat flag.
REQ-009 SHALL have port req_ready  output  N_REQ  per-requester beat accept.
REQ-010 SHALL have port out_valid  output  1  beat valid toward the packet adder.
REQ-011 SHALL have port out_data  output  DATA_W  beat data toward the packet adder.
REQ-012 SHALL have port out_last  output  1  last beat toward the packet adder.
REQ-013 SHALL have port out_ready  input  1  packet adder accept.
REQ-014 SHALL have port grant_id  output  clog2(N_REQ)  index of current owner; valid when busy=1.
REQ-015 SHALL have port busy  output  1  high while a packet transfer owns the adder.
REQ-016 SHALL have port wdog_err  output  1  one-cycle pulse on watchdog release.

Function
REQ-017 SHALL implement states IDLE, XFER; beat handshake = valid & ready in the same cycle.
REQ-018 SHALL, in IDLE, select the first requester with req_valid=1 scanning from priority pointer ptr upward modulo N_REQ; transition to XFER at the next edge with grant_id registered.
REQ-019 SHALL have one cycle of arbitration latency: IDLE cycle with any req_valid -> first beat forwarded no earlier than the following cycle.
REQ-020 SHALL, in XFER, combinationally forward out_valid=req_valid[grant_id], out_data, out_last=req_last[grant_id], and req_ready[grant_id]=out_ready; all other req_ready SHALL be 0.
REQ-021 SHALL drive req_ready all 0 and out_valid=0 in IDLE.
REQ-022 SHALL hold the grant for the whole packet; requests from other requesters SHALL NOT preempt.
REQ-023 SHALL, on handshake with out_last=1, return to IDLE at the next edge and set ptr=(grant_id+1) mod N_REQ.
REQ-024 SHALL count accepted beats in XFER (counter cleared on entering XFER); when MAX_BEATS beats are accepted without last, SHALL return to IDLE, advance ptr as in REQ-023, pulse wdog_err for one cycle.
REQ-025 SHALL, if the final accepted beat is both last and the MAX_BEATS-th, treat it as normal completion (no wdog_err).
REQ-026 SHALL keep XFER with out_valid=0 while the owner deasserts req_valid mid-packet (bubbles allowed, counter not incremented).
REQ-027 SHALL support back-to-back packets: IDLE re-arbitration immediately after completion, same requester regranted only if no other requester is valid.
REQ-028 SHALL assert busy=1 exactly while in XFER.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously enter IDLE, ptr=0, grant_id=0, beat counter=0, busy=0, wdog_err=0, out_valid=0, req_ready=0.
REQ-030 SHALL, on reset mid-packet, abandon the packet with no further beats forwarded; post-reset arbitration restarts from requester 0.

Verification
REQ-031 SHALL verify single request: req_valid=0001, 3-beat packet, out_ready=1 -> busy high cycle after request, beats forwarded unchanged, grant_id=0, ptr=1 after.
REQ-032 SHALL verify round robin: all four valid continuously, 2-beat packets -> grant order 0,1,2,3,0.
REQ-033 SHALL verify backpressure: out_ready toggling 1,0,1,0 -> req_ready[owner] mirrors out_ready, no beat lost or duplicated.
REQ-034 SHALL verify watchdog: MAX_BEATS=16, owner never asserts last -> after 16th accepted beat busy falls, wdog_err pulses once, next requester granted.
REQ-035 SHALL verify no preemption: requester 2 raises valid during requester 1's packet -> grant_id stays 1 until last accepted, then 2.
REQ-036 SHALL verify reset mid-packet: rst_n low at beat 2 -> out_valid/busy 0 immediately, first grant after reset to lowest valid index from 0.
